// File: rtl/fsm_pkg.sv
// Shared types and limits for the number-guessing game controller.
// Covers the state encoding, status codes, per-difficulty limits and round thresholds.
package fsm_pkg;

    typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;

    localparam logic [1:0] WL_PLAY = 2'd3;
    localparam logic [1:0] WL_WIN  = 2'd1;
    localparam logic [1:0] WL_LOSE = 2'd0;

    localparam logic [1:0] D1_DIGITS  = 2'd1;
    localparam logic [2:0] D1_GUESSES = 3'd3;
    localparam logic [6:0] D1_TIME    = 7'd30;
    localparam logic [1:0] D2_DIGITS  = 2'd2;
    localparam logic [2:0] D2_GUESSES = 3'd4;
    localparam logic [6:0] D2_TIME    = 7'd60;
    localparam logic [1:0] D3_DIGITS  = 2'd3;
    localparam logic [2:0] D3_GUESSES = 3'd5;
    localparam logic [6:0] D3_TIME    = 7'd90;

    localparam logic [3:0] ROUND_D2  = 4'd4;
    localparam logic [3:0] ROUND_D3  = 4'd7;
    localparam logic [3:0] ROUND_WIN = 4'd10;

    // Remaining-guess count that floors at zero instead of wrapping.
    function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
        return (b >= a) ? 3'd0 : (a - b);
    endfunction

endpackage

// File: rtl/fsm_diff_decode.sv
// Combinational round-to-difficulty decode.
// Rounds past the last level keep the hardest limits and raise win_round.
module fsm_diff_decode
    import fsm_pkg::*;
(
    input  logic [3:0] round,
    output logic [1:0] max_digit,
    output logic [2:0] max_guesses,
    output logic [6:0] max_time,
    output logic       win_round
);

    always_comb begin
        max_digit   = D1_DIGITS;
        max_guesses = D1_GUESSES;
        max_time    = D1_TIME;
        win_round   = 1'b0;
        if (round >= ROUND_WIN) begin
            max_digit   = D3_DIGITS;
            max_guesses = D3_GUESSES;
            max_time    = D3_TIME;
            win_round   = 1'b1;
        end else if (round >= ROUND_D3) begin
            max_digit   = D3_DIGITS;
            max_guesses = D3_GUESSES;
            max_time    = D3_TIME;
        end else if (round >= ROUND_D2) begin
            max_digit   = D2_DIGITS;
            max_guesses = D2_GUESSES;
            max_time    = D2_TIME;
        end
    end

endmodule

// File: rtl/fsm.sv
// Game-control state machine: tracks PLAY/WIN/LOSE and drives registered
// digit count, remaining guesses and win/lose status.
module fsm
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       restart,
    input  logic [2:0] incorrect_guesses,
    input  logic [3:0] round,
    input  logic [6:0] timer,
    output logic [1:0] Max_digit,
    output logic [1:0] WINorLOSE,
    output logic [2:0] guesses_left
);

    state_t     state_q, state_d;
    logic [1:0] max_digit_q, max_digit_d;
    logic [2:0] guesses_left_q, guesses_left_d;
    logic [1:0] wl_q, wl_d;

    logic [1:0] dec_digit;
    logic [2:0] dec_guesses;
    logic [6:0] dec_time_unused;
    logic       dec_win_round;
    logic       lose_cond;

    // A timer above the level limit is legal, so the time limit is not used for checking.
    fsm_diff_decode u_decode (
        .round       (round),
        .max_digit   (dec_digit),
        .max_guesses (dec_guesses),
        .max_time    (dec_time_unused),
        .win_round   (dec_win_round)
    );

    assign lose_cond = (timer == 7'd0) || (incorrect_guesses >= dec_guesses);

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q        <= PLAY;
            max_digit_q    <= D1_DIGITS;
            guesses_left_q <= D1_GUESSES;
            wl_q           <= WL_PLAY;
        end else begin
            state_q        <= state_d;
            max_digit_q    <= max_digit_d;
            guesses_left_q <= guesses_left_d;
            wl_q           <= wl_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        max_digit_d    = max_digit_q;
        guesses_left_d = guesses_left_q;
        wl_d           = wl_q;
        unique case (state_q)
            PLAY: begin
                max_digit_d    = dec_digit;
                guesses_left_d = sat_sub(dec_guesses, incorrect_guesses);
                // Losing takes precedence over reaching the final round.
                if (lose_cond) begin
                    state_d = LOSE;
                    wl_d    = WL_LOSE;
                end else if (dec_win_round) begin
                    state_d = WIN;
                    wl_d    = WL_WIN;
                end else begin
                    wl_d    = WL_PLAY;
                end
            end
            WIN, LOSE: begin
                state_d = state_q;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    assign Max_digit    = max_digit_q;
    assign guesses_left = guesses_left_q;
    assign WINorLOSE    = wl_q;

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the game-control FSM with an expected-value scoreboard.
module tb_fsm;

    logic       clk;
    logic       restart;
    logic [2:0] incorrect_guesses;
    logic [3:0] round;
    logic [6:0] timer;
    logic [1:0] Max_digit;
    logic [1:0] WINorLOSE;
    logic [2:0] guesses_left;

    typedef struct {
        logic [1:0] md;
        logic [2:0] gl;
        logic [1:0] wl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fsm dut (
        .clk               (clk),
        .restart           (restart),
        .incorrect_guesses (incorrect_guesses),
        .round             (round),
        .timer             (timer),
        .Max_digit         (Max_digit),
        .WINorLOSE         (WINorLOSE),
        .guesses_left      (guesses_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the expected registered outputs, then check after the edge.
    task automatic step(input logic rs, input logic [3:0] rd, input logic [6:0] tm,
                        input logic [2:0] inc, input logic [1:0] emd,
                        input logic [2:0] egl, input logic [1:0] ewl, input string tag);
        exp_t e;
        restart           = rs;
        round             = rd;
        timer             = tm;
        incorrect_guesses = inc;
        sb.push_back('{md: emd, gl: egl, wl: ewl, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (Max_digit === e.md) else begin
            errors++;
            $error("FAIL %s Max_digit: got %0d expected %0d", e.tag, Max_digit, e.md);
        end
        checks++;
        assert (guesses_left === e.gl) else begin
            errors++;
            $error("FAIL %s guesses_left: got %0d expected %0d", e.tag, guesses_left, e.gl);
        end
        checks++;
        assert (WINorLOSE === e.wl) else begin
            errors++;
            $error("FAIL %s WINorLOSE: got %0d expected %0d", e.tag, WINorLOSE, e.wl);
        end
    endtask

    initial begin
        restart           = 1'b1;
        round             = 4'd1;
        timer             = 7'd30;
        incorrect_guesses = 3'd0;

        // Reset and idle play in D1
        step(1'b1, 4'd1, 7'd30, 3'd0, 2'd1, 3'd3, 2'd3, "reset");
        step(1'b0, 4'd1, 7'd30, 3'd0, 2'd1, 3'd3, 2'd3, "d1_play");

        // Countdown to zero, then timer wrap and round change while lost
        for (int t = 29; t >= 1; t--)
            step(1'b0, 4'd1, 7'(t), 3'd0, 2'd1, 3'd3, 2'd3, "d1_countdown");
        step(1'b0, 4'd1, 7'd0,   3'd0, 2'd1, 3'd3, 2'd0, "timeout_lose");
        step(1'b0, 4'd1, 7'd127, 3'd0, 2'd1, 3'd3, 2'd0, "timer_wrap_sticky");
        step(1'b0, 4'd7, 7'd90,  3'd0, 2'd1, 3'd3, 2'd0, "lose_ignores_round");

        // Restart out of LOSE
        step(1'b1, 4'd1, 7'd30, 3'd0, 2'd1, 3'd3, 2'd3, "restart_from_lose");

        // Difficulty levels
        step(1'b0, 4'd4, 7'd60, 3'd0, 2'd2, 3'd4, 2'd3, "d2_level");
        step(1'b0, 4'd5, 7'd100, 3'd3, 2'd2, 3'd1, 2'd3, "d2_timer_above_max");
        step(1'b0, 4'd7, 7'd90, 3'd0, 2'd3, 3'd5, 2'd3, "d3_level");

        // D3 wrong guesses count down, then lose by guesses and no wrap
        for (int i = 1; i <= 4; i++)
            step(1'b0, 4'd7, 7'd90, 3'(i), 2'd3, 3'(5 - i), 2'd3, "d3_guesses");
        step(1'b0, 4'd7, 7'd90, 3'd5, 2'd3, 3'd0, 2'd0, "d3_guess_lose");
        step(1'b0, 4'd7, 7'd90, 3'd6, 2'd3, 3'd0, 2'd0, "d3_guess_nowrap");

        // Restart mid-round has priority over inputs
        step(1'b1, 4'd7, 7'd0, 3'd6, 2'd1, 3'd3, 2'd3, "restart_priority");
        step(1'b0, 4'd8, 7'd50, 3'd1, 2'd3, 3'd4, 2'd3, "d3_midround");
        step(1'b1, 4'd8, 7'd50, 3'd1, 2'd1, 3'd3, 2'd3, "restart_midround");

        // Round decreasing re-decodes; D1 lose by guesses
        step(1'b0, 4'd8, 7'd50, 3'd0, 2'd3, 3'd5, 2'd3, "round_high");
        step(1'b0, 4'd2, 7'd50, 3'd1, 2'd1, 3'd2, 2'd3, "round_decrease");
        step(1'b0, 4'd2, 7'd50, 3'd3, 2'd1, 3'd0, 2'd0, "d1_guess_lose");

        // Win and stickiness
        step(1'b1, 4'd1, 7'd30, 3'd0, 2'd1, 3'd3, 2'd3, "restart_before_win");
        step(1'b0, 4'd10, 7'd90, 3'd0, 2'd3, 3'd5, 2'd1, "win");
        step(1'b0, 4'd1, 7'd0,  3'd7, 2'd3, 3'd5, 2'd1, "win_sticky");
        step(1'b0, 4'd12, 7'd5, 3'd2, 2'd3, 3'd5, 2'd1, "win_sticky2");

        // Lose wins a tie with the final round
        step(1'b1, 4'd1, 7'd30, 3'd0, 2'd1, 3'd3, 2'd3, "restart_before_tie");
        step(1'b0, 4'd10, 7'd0, 3'd0, 2'd3, 3'd5, 2'd0, "lose_priority");
        step(1'b0, 4'd10, 7'd90, 3'd0, 2'd3, 3'd5, 2'd0, "lose_priority_sticky");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
